// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// mem_stage_pkg : widths, FSM state type and MEM/WB record for mem_stage
// Rev 1.0
// ============================================================================
package mem_stage_pkg;

  localparam int ADDR_W           = 32;
  localparam int DATA_W           = 32;
  localparam int REG_W            = 5;
  localparam int MAX_WAIT_DEFAULT = 15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic              write_reg;
    logic              write_back;
    logic              bus_err;
    logic              misalign;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_output;
    logic [REG_W-1:0]  rt_or_rd;
  } mem_wb_t;

endpackage
`default_nettype wire

// File: rtl/mem_stage_wb_reg.sv
`default_nettype none
// ============================================================================
// mem_wb_reg : MEM/WB pipeline register; loads when not stalled, else bubbles
// Rev 1.0
// ============================================================================
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    stall,
  input  mem_wb_t d,
  output mem_wb_t q
);

  mem_wb_t mw_d, mw_q;

  // Bubble kills the control bits but keeps the data fields stable.
  always_comb begin
    mw_d = d;
    if (stall) begin
      mw_d            = mw_q;
      mw_d.valid      = 1'b0;
      mw_d.write_reg  = 1'b0;
      mw_d.write_back = 1'b0;
      mw_d.bus_err    = 1'b0;
      mw_d.misalign   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mw_q <= '0;
    else     mw_q <= mw_d;
  end

  assign q = mw_q;

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage : MEM pipeline stage with handshaked data-memory port and timeout
// Optional MEM_STAGE_ALIGN_CHECK_EN: unaligned memory ops bypass the bus.
// Rev 1.0
// ============================================================================
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              write_reg,
  input  logic              write_back,
  input  logic              branch,
  input  logic              ALU_zero_flag,
  input  logic [ADDR_W-1:0] ALU_output,
  input  logic [DATA_W-1:0] readData2,
  input  logic [ADDR_W-1:0] next,
  input  logic [REG_W-1:0]  rt_or_rd,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall,
  output logic              pc_src,
  output logic [ADDR_W-1:0] branch_target,
  output logic              o_valid,
  output logic              o_write_reg,
  output logic              o_write_back,
  output logic              o_bus_err,
  output logic              o_misalign,
  output logic [DATA_W-1:0] o_read_data,
  output logic [DATA_W-1:0] o_ALU_output,
  output logic [REG_W-1:0]  o_rt_or_rd
);

  localparam int                CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(MAX_WAIT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d, we_q, we_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic              mem_op, misalign, issue, is_read;
  mem_wb_t           wb_d, wb_q;

  assign mem_op  = mem_read | mem_write;
  assign is_read = mem_read & ~mem_write;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  assign misalign = mem_op & (ALU_output[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign issue = mem_op & ~misalign;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d = S_BUSY;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = mem_write;
          addr_d  = ALU_output;
          wdata_d = readData2;
          err_d   = 1'b0;
        end
      end
      S_BUSY: begin
        // An ack on the final wait cycle still wins over the timeout.
        if (dmem_ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          rdata_d = dmem_rdata;
        end else if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Reset gates stall so the pipeline is released while rst is held.
  assign stall = ~rst & (((state_q == S_IDLE) & issue) | (state_q == S_BUSY));

  assign pc_src        = branch & ALU_zero_flag & ~stall;
  assign branch_target = next;

  always_comb begin
    wb_d            = '0;
    wb_d.valid      = 1'b1;
    wb_d.write_reg  = write_reg & ~misalign & ~((state_q == S_DONE) & err_q);
    wb_d.write_back = write_back;
    wb_d.bus_err    = (state_q == S_DONE) & err_q;
    wb_d.misalign   = misalign;
    wb_d.read_data  = ((state_q == S_DONE) & is_read) ? rdata_q : '0;
    wb_d.alu_output = ALU_output;
    wb_d.rt_or_rd   = rt_or_rd;
  end

  mem_wb_reg u_mem_wb_reg (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .d     (wb_d),
    .q     (wb_q)
  );

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign o_valid      = wb_q.valid;
  assign o_write_reg  = wb_q.write_reg;
  assign o_write_back = wb_q.write_back;
  assign o_bus_err    = wb_q.bus_err;
  assign o_misalign   = wb_q.misalign;
  assign o_read_data  = wb_q.read_data;
  assign o_ALU_output = wb_q.alu_output;
  assign o_rt_or_rd   = wb_q.rt_or_rd;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_stage : directed table-driven bench for mem_stage
// Rev 1.0
// ============================================================================
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, write_reg, write_back, branch, ALU_zero_flag;
  logic [31:0] ALU_output, readData2, next;
  logic [4:0]  rt_or_rd;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall, pc_src;
  logic [31:0] branch_target;
  logic        o_valid, o_write_reg, o_write_back, o_bus_err, o_misalign;
  logic [31:0] o_read_data, o_ALU_output;
  logic [4:0]  o_rt_or_rd;

  int checks = 0;
  int errors = 0;

  mem_stage #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .write_reg(write_reg),
    .write_back(write_back), .branch(branch), .ALU_zero_flag(ALU_zero_flag),
    .ALU_output(ALU_output), .readData2(readData2), .next(next), .rt_or_rd(rt_or_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
    .o_valid(o_valid), .o_write_reg(o_write_reg), .o_write_back(o_write_back),
    .o_bus_err(o_bus_err), .o_misalign(o_misalign), .o_read_data(o_read_data),
    .o_ALU_output(o_ALU_output), .o_rt_or_rd(o_rt_or_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        br, zf, wr, wb, ack;
    logic [31:0] alu, nxt;
    logic [4:0]  rd;
    logic        exp_pc_src;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop_inputs();
    mem_read = 0; mem_write = 0; write_reg = 0; write_back = 0;
    branch = 0; ALU_zero_flag = 0; ALU_output = 0; readData2 = 0;
    next = 0; rt_or_rd = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  initial begin
    vecs[0] = '{br:0, zf:0, wr:1, wb:0, ack:0, alu:32'h10,       nxt:32'h100,  rd:5'd5,  exp_pc_src:0};
    vecs[1] = '{br:1, zf:1, wr:0, wb:0, ack:0, alu:32'h0,        nxt:32'h2000, rd:5'd0,  exp_pc_src:1};
    vecs[2] = '{br:1, zf:0, wr:1, wb:1, ack:1, alu:32'hFFFFFFFF, nxt:32'h44,   rd:5'd31, exp_pc_src:0};
    vecs[3] = '{br:0, zf:1, wr:0, wb:1, ack:0, alu:32'h12345678, nxt:32'h0,    rd:5'd17, exp_pc_src:0};

    rst = 1'b1;
    nop_inputs();
    #2;
    chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    step();
    rst = 1'b0;

    // Non-memory ops pass through in one cycle
    for (int i = 0; i < 4; i++) begin
      branch = vecs[i].br; ALU_zero_flag = vecs[i].zf; write_reg = vecs[i].wr;
      write_back = vecs[i].wb; dmem_ack = vecs[i].ack; ALU_output = vecs[i].alu;
      next = vecs[i].nxt; rt_or_rd = vecs[i].rd;
      #1;
      chk($sformatf("v%0d_stall", i), {31'd0, stall}, 32'd0);
      chk($sformatf("v%0d_pc_src", i), {31'd0, pc_src}, {31'd0, vecs[i].exp_pc_src});
      chk($sformatf("v%0d_branch_target", i), branch_target, vecs[i].nxt);
      step();
      chk($sformatf("v%0d_o_valid", i), {31'd0, o_valid}, 32'd1);
      chk($sformatf("v%0d_o_ALU_output", i), o_ALU_output, vecs[i].alu);
      chk($sformatf("v%0d_o_rt_or_rd", i), {27'd0, o_rt_or_rd}, {27'd0, vecs[i].rd});
      chk($sformatf("v%0d_o_write_reg", i), {31'd0, o_write_reg}, {31'd0, vecs[i].wr});
      chk($sformatf("v%0d_o_write_back", i), {31'd0, o_write_back}, {31'd0, vecs[i].wb});
      chk($sformatf("v%0d_o_read_data", i), o_read_data, 32'd0);
      chk($sformatf("v%0d_dmem_req", i), {31'd0, dmem_req}, 32'd0);
    end
    nop_inputs();

    // Load at 0x40, ack on the second BUSY cycle
    mem_read = 1; ALU_output = 32'h40; write_reg = 1; write_back = 1; rt_or_rd = 5'd7;
    branch = 1; ALU_zero_flag = 1;
    #1;
    chk("ld_stall_c0", {31'd0, stall}, 32'd1);
    chk("ld_pc_src_masked", {31'd0, pc_src}, 32'd0);
    step();
    chk("ld_stall_c1", {31'd0, stall}, 32'd1);
    chk("ld_req", {31'd0, dmem_req}, 32'd1);
    chk("ld_we", {31'd0, dmem_we}, 32'd0);
    chk("ld_addr", dmem_addr, 32'h40);
    chk("ld_bubble_valid", {31'd0, o_valid}, 32'd0);
    chk("ld_bubble_wr", {31'd0, o_write_reg}, 32'd0);
    step();
    chk("ld_stall_c2", {31'd0, stall}, 32'd1);
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    step();
    dmem_ack = 0; dmem_rdata = 32'h0;
    #1;
    chk("ld_done_stall", {31'd0, stall}, 32'd0);
    chk("ld_done_req", {31'd0, dmem_req}, 32'd0);
    chk("ld_done_pc_src", {31'd0, pc_src}, 32'd1);
    step();
    nop_inputs();
    chk("ld_o_read_data", o_read_data, 32'hDEADBEEF);
    chk("ld_o_write_back", {31'd0, o_write_back}, 32'd1);
    chk("ld_o_write_reg", {31'd0, o_write_reg}, 32'd1);
    chk("ld_o_valid", {31'd0, o_valid}, 32'd1);
    chk("ld_o_rt_or_rd", {27'd0, o_rt_or_rd}, 32'd7);

    // Store (read+write both set -> write) at 0x80, held over 3 unacked cycles
    mem_read = 1; mem_write = 1; readData2 = 32'h1234; ALU_output = 32'h80; rt_or_rd = 5'd3;
    step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("st_req_%0d", i), {31'd0, dmem_req}, 32'd1);
      chk($sformatf("st_we_%0d", i), {31'd0, dmem_we}, 32'd1);
      chk($sformatf("st_wdata_%0d", i), dmem_wdata, 32'h1234);
      chk($sformatf("st_addr_%0d", i), dmem_addr, 32'h80);
      step();
    end
    dmem_ack = 1; dmem_rdata = 32'hFFFFFFFF;
    step();
    dmem_ack = 0;
    chk("st_done_req", {31'd0, dmem_req}, 32'd0);
    step();
    nop_inputs();
    chk("st_o_read_data", o_read_data, 32'd0);
    chk("st_o_valid", {31'd0, o_valid}, 32'd1);
    chk("st_o_ALU_output", o_ALU_output, 32'h80);

    // Load with no ack: 15 BUSY cycles then bus error
    mem_read = 1; ALU_output = 32'h100; write_reg = 1; write_back = 1; rt_or_rd = 5'd9;
    step();
    for (int i = 1; i < 15; i++) step();
    chk("to_busy15_stall", {31'd0, stall}, 32'd1);
    chk("to_busy15_req", {31'd0, dmem_req}, 32'd1);
    step();
    chk("to_done_stall", {31'd0, stall}, 32'd0);
    chk("to_done_req", {31'd0, dmem_req}, 32'd0);
    step();
    nop_inputs();
    chk("to_o_bus_err", {31'd0, o_bus_err}, 32'd1);
    chk("to_o_write_reg", {31'd0, o_write_reg}, 32'd0);
    chk("to_o_read_data", o_read_data, 32'd0);
    chk("to_o_valid", {31'd0, o_valid}, 32'd1);
    write_reg = 1; ALU_output = 32'h5;
    #1;
    chk("to_idle_stall", {31'd0, stall}, 32'd0);
    step();
    chk("to_next_bus_err", {31'd0, o_bus_err}, 32'd0);
    chk("to_next_write_reg", {31'd0, o_write_reg}, 32'd1);

    // Reset asserted mid-BUSY
    nop_inputs();
    mem_read = 1; ALU_output = 32'h40; write_reg = 1; rt_or_rd = 5'd4;
    step();
    chk("rb_req_before", {31'd0, dmem_req}, 32'd1);
    rst = 1;
    #1;
    chk("rb_req", {31'd0, dmem_req}, 32'd0);
    chk("rb_stall", {31'd0, stall}, 32'd0);
    chk("rb_o_ALU_output", o_ALU_output, 32'd0);
    chk("rb_o_rt_or_rd", {27'd0, o_rt_or_rd}, 32'd0);
    chk("rb_o_flags", {27'd0, o_valid, o_write_reg, o_write_back, o_bus_err, o_misalign}, 32'd0);
    chk("rb_o_read_data", o_read_data, 32'd0);
    chk("rb_dmem_addr", dmem_addr, 32'd0);
    step();
    rst = 0;
    #1;
    chk("rb_restart_stall", {31'd0, stall}, 32'd1);
    step();
    chk("rb_restart_req", {31'd0, dmem_req}, 32'd1);
    dmem_ack = 1; dmem_rdata = 32'h0BADF00D;
    step();
    dmem_ack = 0;
    step();
    nop_inputs();
    chk("rb_restart_read_data", o_read_data, 32'h0BADF00D);

    // Unaligned load at 0x42
    mem_read = 1; ALU_output = 32'h42; write_reg = 1; rt_or_rd = 5'd2;
    #1;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    chk("ua_stall", {31'd0, stall}, 32'd0);
    step();
    nop_inputs();
    chk("ua_req", {31'd0, dmem_req}, 32'd0);
    chk("ua_o_misalign", {31'd0, o_misalign}, 32'd1);
    chk("ua_o_write_reg", {31'd0, o_write_reg}, 32'd0);
    chk("ua_o_valid", {31'd0, o_valid}, 32'd1);
`else
    chk("ua_stall", {31'd0, stall}, 32'd1);
    step();
    chk("ua_req", {31'd0, dmem_req}, 32'd1);
    chk("ua_addr", dmem_addr, 32'h42);
    dmem_ack = 1;
    step();
    dmem_ack = 0;
    step();
    nop_inputs();
    chk("ua_o_misalign", {31'd0, o_misalign}, 32'd0);
    chk("ua_o_valid", {31'd0, o_valid}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: maximum BUSY cycles to wait for dmem_ack before declaring a bus error.
REQ-002 SHALL have port clk, input, 1: single rising-edge clock.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have inputs mem_read, mem_write, write_reg, write_back, branch, ALU_zero_flag, each 1 bit: EX/MEM control and flag outputs.
REQ-005 SHALL have inputs ALU_output[31:0] (address or result), readData2[31:0] (store data), next[31:0] (branch target), rt_or_rd[4:0] (destination register).
REQ-006 SHALL have outputs dmem_req, dmem_we (1 bit each), dmem_addr[31:0] and dmem_wdata[31:0]: data-memory request side.
REQ-007 SHALL have inputs dmem_rdata[31:0] and dmem_ack (1 bit): data-memory response side.
REQ-008 SHALL have outputs stall, pc_src (1 bit each) and branch_target[31:0]: pipeline hold and branch redirect.
REQ-009 SHALL have MEM/WB outputs o_valid, o_write_reg, o_write_back, o_bus_err, o_misalign (1 bit each), plus o_read_data[31:0], o_ALU_output[31:0] and o_rt_or_rd[4:0].

Function
REQ-010 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-011 A memory op is mem_read|mem_write; when both are asserted, the op SHALL be treated as a write.
REQ-012 IDLE with a memory op SHALL go to BUSY and register dmem_req=1, dmem_we=mem_write, dmem_addr=ALU_output and dmem_wdata=readData2.
REQ-013 IDLE without a memory op SHALL stay in IDLE, and the instruction SHALL pass to MEM/WB in 1 cycle.
REQ-014 In BUSY, dmem_req and dmem_addr/dmem_wdata/dmem_we SHALL hold stable until dmem_ack; on dmem_ack the FSM SHALL capture dmem_rdata and go to DONE, deasserting dmem_req.
REQ-015 In BUSY, a wait counter SHALL count from 0; if it reaches MAX_WAIT without dmem_ack, the FSM SHALL go to DONE with bus error set, o_read_data=0 and write_reg suppressed.
REQ-016 DONE SHALL last exactly 1 cycle and then go to IDLE.
REQ-017 A memory op SHALL take at least 3 cycles: IDLE, one or more BUSY cycles, then DONE.
REQ-018 stall SHALL be combinational: 1 when (IDLE and memory op) or BUSY; 0 in DONE and for non-memory ops.
REQ-019 dmem_ack outside BUSY SHALL be ignored.
REQ-020 pc_src SHALL equal branch & ALU_zero_flag & ~stall, combinationally.
REQ-021 branch_target SHALL equal next, combinationally.
REQ-022 On each edge with stall=0, MEM/WB outputs SHALL load from the current inputs and o_valid SHALL be set to 1.
REQ-023 o_read_data SHALL take the captured data for reads and 0 otherwise.
REQ-024 On each edge with stall=1, a bubble SHALL be inserted: o_valid=0, o_write_reg=0 and o_write_back=0, with data outputs holding.
REQ-025 o_bus_err SHALL be 1 only for the instruction that timed out.

Reset
REQ-026 rst SHALL force state=IDLE, wait counter=0, and dmem_req=dmem_we=0 immediately, including mid-BUSY.
REQ-027 rst SHALL clear all o_* outputs and dmem_addr/dmem_wdata to 0.
REQ-028 The first operation after rst deasserts SHALL start from IDLE.

Configuration
REQ-029 SHALL support macro MEM_STAGE_ALIGN_CHECK_EN.
REQ-030 With MEM_STAGE_ALIGN_CHECK_EN defined, a memory op with ALU_output[1:0]!=0 SHALL issue no request and remain non-stalling. It SHALL pass in 1 cycle with o_misalign=1 and o_write_reg=0.
REQ-031 Without MEM_STAGE_ALIGN_CHECK_EN, o_misalign SHALL be tied to 0 and unaligned addresses SHALL be issued unchanged.

Structure
REQ-032 Package mem_stage_pkg SHALL hold the FSM state typedef, the MAX_WAIT default, and the address/data/register-index width constants.
REQ-033 The MEM/WB output register SHALL be a sub-module named mem_wb_reg with load (stall=0) and bubble (stall=1) behaviour.

Verification
REQ-034 Test: non-memory op with ALU_output=0x10, write_reg=1, rt_or_rd=5 -> next edge: o_valid=1, o_ALU_output=0x10, o_rt_or_rd=5, stall never asserted.
REQ-035 Test: load at ALU_output=0x40 with dmem_ack 2 cycles after dmem_req and rdata=0xDEADBEEF -> stall high for 3 cycles, then o_read_data=0xDEADBEEF and o_write_back=1.
REQ-036 Test: store with readData2=0x1234 at address 0x80 -> dmem_we=1, dmem_wdata=0x1234, dmem_addr=0x80 held until ack; o_read_data=0.
REQ-037 Test: load with no ack -> after MAX_WAIT=15 BUSY cycles, o_bus_err=1, o_write_reg=0, FSM back in IDLE.
REQ-038 Test: rst asserted in BUSY -> dmem_req=0 in the same cycle, stall=0, all o_* outputs=0.
REQ-039 Test: with MEM_STAGE_ALIGN_CHECK_EN, load at 0x42 -> no dmem_req, o_misalign=1; without the macro, dmem_addr=0x42 is requested.
